// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the CPU
// control unit (port 0) and the debug/loader port (port 1).
module mem_port_arbiter #(
    parameter int AWIDTH  = 5,
    parameter int DWIDTH  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [DWIDTH-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_ack,
    output logic [DWIDTH-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       owner;
    logic       last_owner;
    logic       lat_we;
    logic [3:0] cnt;
    logic       any_req;
    logic       win;

    // owner/last_owner encoding: 0 = cpu, 1 = dbg
    assign any_req = cpu_req | dbg_req;
    assign win     = (cpu_req && dbg_req) ? ~last_owner : dbg_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner      <= win;
                        last_owner <= win;
                        lat_we     <= win ? dbg_we : cpu_we;
                        mem_addr   <= win ? dbg_addr : cpu_addr;
                        mem_wdata  <= win ? dbg_wdata : cpu_wdata;
                    end
                end
                S_ISSUE: begin
                    cnt <= 4'(MEM_LAT);
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1 && !lat_we) begin
                        if (owner) begin
                            dbg_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                S_ACK: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (any_req) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        cpu_ack = 1'b0;
        dbg_ack = 1'b0;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b0;
        unique case (state)
            S_IDLE: begin
            end
            S_ISSUE: begin
                cpu_gnt = ~owner;
                dbg_gnt = owner;
                mem_en  = 1'b1;
                mem_we  = lat_we;
                busy    = 1'b1;
            end
            S_WAIT: begin
                cpu_gnt = ~owner;
                dbg_gnt = owner;
                busy    = 1'b1;
            end
            S_ACK: begin
                cpu_gnt = ~owner;
                dbg_gnt = owner;
                cpu_ack = ~owner;
                dbg_ack = owner;
                busy    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table on a MEM_LAT=1
// instance plus hand sequences on a MEM_LAT=3 instance.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instance a: MEM_LAT=1
    logic       a_creq, a_cwe, a_cgnt, a_cack;
    logic [4:0] a_caddr;
    logic [7:0] a_cwd, a_crd;
    logic       a_dreq, a_dwe, a_dgnt, a_dack;
    logic [4:0] a_daddr;
    logic [7:0] a_dwd, a_drd;
    logic       a_men, a_mwe, a_busy;
    logic [4:0] a_maddr;
    logic [7:0] a_mwd, a_mrd;

    // instance b: MEM_LAT=3
    logic       b_creq, b_cwe, b_cgnt, b_cack;
    logic [4:0] b_caddr;
    logic [7:0] b_cwd, b_crd;
    logic       b_dreq, b_dwe, b_dgnt, b_dack;
    logic [4:0] b_daddr;
    logic [7:0] b_dwd, b_drd;
    logic       b_men, b_mwe, b_busy;
    logic [4:0] b_maddr;
    logic [7:0] b_mwd, b_mrd;

    mem_port_arbiter #(.AWIDTH(5), .DWIDTH(8), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(a_creq), .cpu_we(a_cwe), .cpu_addr(a_caddr),
        .cpu_wdata(a_cwd), .cpu_gnt(a_cgnt), .cpu_ack(a_cack),
        .cpu_rdata(a_crd),
        .dbg_req(a_dreq), .dbg_we(a_dwe), .dbg_addr(a_daddr),
        .dbg_wdata(a_dwd), .dbg_gnt(a_dgnt), .dbg_ack(a_dack),
        .dbg_rdata(a_drd),
        .mem_en(a_men), .mem_we(a_mwe), .mem_addr(a_maddr),
        .mem_wdata(a_mwd), .mem_rdata(a_mrd), .busy(a_busy)
    );

    mem_port_arbiter #(.AWIDTH(5), .DWIDTH(8), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(b_creq), .cpu_we(b_cwe), .cpu_addr(b_caddr),
        .cpu_wdata(b_cwd), .cpu_gnt(b_cgnt), .cpu_ack(b_cack),
        .cpu_rdata(b_crd),
        .dbg_req(b_dreq), .dbg_we(b_dwe), .dbg_addr(b_daddr),
        .dbg_wdata(b_dwd), .dbg_gnt(b_dgnt), .dbg_ack(b_dack),
        .dbg_rdata(b_drd),
        .mem_en(b_men), .mem_we(b_mwe), .mem_addr(b_maddr),
        .mem_wdata(b_mwd), .mem_rdata(b_mrd), .busy(b_busy)
    );

    // memory models: contents reload while reset is held
    logic [7:0] m1 [32];
    logic [7:0] m3 [32];
    logic [7:0] p1;
    logic [7:0] p3 [3];

    function automatic logic [7:0] init_a(input int i);
        case (i)
            5:       return 8'hA3;
            7:       return 8'h4E;
            9:       return 8'h3C;
            default: return 8'(i * 7 + 1);
        endcase
    endfunction

    function automatic logic [7:0] init_b(input int i);
        case (i)
            5:       return 8'hD2;
            6:       return 8'hE7;
            default: return 8'(i * 3 + 2);
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m1[i] <= init_a(i);
        end else if (a_men && a_mwe) begin
            m1[a_maddr] <= a_mwd;
        end
        p1 <= (a_men && !a_mwe) ? m1[a_maddr] : 8'h00;
    end
    assign a_mrd = p1;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m3[i] <= init_b(i);
        end else if (b_men && b_mwe) begin
            m3[b_maddr] <= b_mwd;
        end
        p3[0] <= (b_men && !b_mwe) ? m3[b_maddr] : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b_mrd = p3[2];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    // mutual exclusion of grants and acks on every cycle out of reset
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if ((a_cgnt && a_dgnt) || (a_cack && a_dack) ||
                (b_cgnt && b_dgnt) || (b_cack && b_dack)) begin
                errors++;
                $display("FAIL excl got gnt/ack overlap at %0t want none",
                         $time);
            end
        end
    end

    typedef struct packed {
        logic       cr;
        logic       cw;
        logic [4:0] ca;
        logic [7:0] cd;
        logic       dr;
        logic       dw;
        logic [4:0] da;
        logic [7:0] dd;
        logic [6:0] fl;
        logic [7:0] crd;
        logic [7:0] drd;
        logic [4:0] ma;
        logic [7:0] mw;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, input logic cw, input logic [4:0] ca,
        input logic [7:0] cd, input logic dr, input logic dw,
        input logic [4:0] da, input logic [7:0] dd,
        input logic [6:0] fl, input logic [7:0] crd,
        input logic [7:0] drd, input logic [4:0] ma,
        input logic [7:0] mw);
        vec_t v;
        v = '{cr, cw, ca, cd, dr, dw, da, dd, fl, crd, drd, ma, mw};
        return v;
    endfunction

    localparam int NV = 36;
    vec_t v [NV];
    logic [6:0] act_fl;
    logic       seen;

    initial begin
        // flags = {cpu_gnt, cpu_ack, dbg_gnt, dbg_ack, mem_en, mem_we, busy}
        // both request after reset: cpu first, then dbg
        v[0]  = mk(1,0,7,0, 1,0,9,0, 7'b0000000, 8'h00,8'h00, 0,8'h00);
        v[1]  = mk(1,0,7,0, 1,0,9,0, 7'b1000101, 8'h00,8'h00, 7,8'h00);
        v[2]  = mk(1,0,7,0, 1,0,9,0, 7'b1000001, 8'h00,8'h00, 7,8'h00);
        v[3]  = mk(1,0,7,0, 1,0,9,0, 7'b1100001, 8'h4E,8'h00, 7,8'h00);
        v[4]  = mk(0,0,0,0, 1,0,9,0, 7'b0000000, 8'h4E,8'h00, 7,8'h00);
        v[5]  = mk(0,0,0,0, 1,0,9,0, 7'b0010101, 8'h4E,8'h00, 9,8'h00);
        v[6]  = mk(0,0,0,0, 1,0,9,0, 7'b0010001, 8'h4E,8'h00, 9,8'h00);
        v[7]  = mk(0,0,0,0, 1,0,9,0, 7'b0011001, 8'h4E,8'h3C, 9,8'h00);
        v[8]  = mk(0,0,0,0, 0,0,0,0, 7'b0000000, 8'h4E,8'h3C, 9,8'h00);
        // cpu read of addr 5; address change after grant is ignored
        v[9]  = mk(1,0,5,0, 0,0,0,0, 7'b0000000, 8'h4E,8'h3C, 9,8'h00);
        v[10] = mk(1,0,6,0, 0,0,0,0, 7'b1000101, 8'h4E,8'h3C, 5,8'h00);
        v[11] = mk(1,0,6,0, 0,0,0,0, 7'b1000001, 8'h4E,8'h3C, 5,8'h00);
        v[12] = mk(1,0,6,0, 0,0,0,0, 7'b1100001, 8'hA3,8'h3C, 5,8'h00);
        v[13] = mk(0,0,0,0, 0,0,0,0, 7'b0000000, 8'hA3,8'h3C, 5,8'h00);
        // dbg write 5C to addr 31
        v[14] = mk(0,0,0,0, 1,1,31,8'h5C, 7'b0000000, 8'hA3,8'h3C, 5,8'h00);
        v[15] = mk(0,0,0,0, 1,1,31,8'h5C, 7'b0010111, 8'hA3,8'h3C, 31,8'h5C);
        v[16] = mk(0,0,0,0, 1,1,31,8'h5C, 7'b0010001, 8'hA3,8'h3C, 31,8'h5C);
        v[17] = mk(0,0,0,0, 1,1,31,8'h5C, 7'b0011001, 8'hA3,8'h3C, 31,8'h5C);
        v[18] = mk(0,0,0,0, 0,0,0,0, 7'b0000000, 8'hA3,8'h3C, 31,8'h5C);
        // both held for four transactions: cpu, dbg, cpu, dbg
        v[19] = mk(1,0,7,0, 1,0,5,0, 7'b0000000, 8'hA3,8'h3C, 31,8'h5C);
        v[20] = mk(1,0,7,0, 1,0,5,0, 7'b1000101, 8'hA3,8'h3C, 7,8'h00);
        v[21] = mk(1,0,7,0, 1,0,5,0, 7'b1000001, 8'hA3,8'h3C, 7,8'h00);
        v[22] = mk(1,0,7,0, 1,0,5,0, 7'b1100001, 8'h4E,8'h3C, 7,8'h00);
        v[23] = mk(1,0,7,0, 1,0,5,0, 7'b0000000, 8'h4E,8'h3C, 7,8'h00);
        v[24] = mk(1,0,7,0, 1,0,5,0, 7'b0010101, 8'h4E,8'h3C, 5,8'h00);
        v[25] = mk(1,0,7,0, 1,0,5,0, 7'b0010001, 8'h4E,8'h3C, 5,8'h00);
        v[26] = mk(1,0,7,0, 1,0,5,0, 7'b0011001, 8'h4E,8'hA3, 5,8'h00);
        v[27] = mk(1,0,7,0, 1,0,5,0, 7'b0000000, 8'h4E,8'hA3, 5,8'h00);
        v[28] = mk(1,0,7,0, 1,0,5,0, 7'b1000101, 8'h4E,8'hA3, 7,8'h00);
        v[29] = mk(1,0,7,0, 1,0,5,0, 7'b1000001, 8'h4E,8'hA3, 7,8'h00);
        v[30] = mk(1,0,7,0, 1,0,5,0, 7'b1100001, 8'h4E,8'hA3, 7,8'h00);
        v[31] = mk(1,0,7,0, 1,0,5,0, 7'b0000000, 8'h4E,8'hA3, 7,8'h00);
        v[32] = mk(1,0,7,0, 1,0,5,0, 7'b0010101, 8'h4E,8'hA3, 5,8'h00);
        v[33] = mk(1,0,7,0, 1,0,5,0, 7'b0010001, 8'h4E,8'hA3, 5,8'h00);
        v[34] = mk(1,0,7,0, 1,0,5,0, 7'b0011001, 8'h4E,8'hA3, 5,8'h00);
        v[35] = mk(0,0,0,0, 0,0,0,0, 7'b0000000, 8'h4E,8'hA3, 5,8'h00);

        {a_creq, a_cwe, a_caddr, a_cwd} = '0;
        {a_dreq, a_dwe, a_daddr, a_dwd} = '0;
        {b_creq, b_cwe, b_caddr, b_cwd} = '0;
        {b_dreq, b_dwe, b_daddr, b_dwd} = '0;

        #1;
        act_fl = {a_cgnt, a_cack, a_dgnt, a_dack, a_men, a_mwe, a_busy};
        chk("rst_flags_a", 0, 32'(act_fl), 0);
        chk("rst_maddr_a", 0, 32'(a_maddr), 0);
        chk("rst_rdata_a", 0, 32'({a_crd, a_drd}), 0);
        chk("rst_busy_b", 0, 32'({b_busy, b_men, b_cgnt}), 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            a_creq  = v[i].cr;
            a_cwe   = v[i].cw;
            a_caddr = v[i].ca;
            a_cwd   = v[i].cd;
            a_dreq  = v[i].dr;
            a_dwe   = v[i].dw;
            a_daddr = v[i].da;
            a_dwd   = v[i].dd;
            @(negedge clk);
            act_fl = {a_cgnt, a_cack, a_dgnt, a_dack, a_men, a_mwe, a_busy};
            chk("flags", i, 32'(act_fl), 32'(v[i].fl));
            chk("cpu_rdata", i, 32'(a_crd), 32'(v[i].crd));
            chk("dbg_rdata", i, 32'(a_drd), 32'(v[i].drd));
            chk("mem_addr", i, 32'(a_maddr), 32'(v[i].ma));
            chk("mem_wdata", i, 32'(a_mwd), 32'(v[i].mw));
        end
        chk("mem31", 0, 32'(m1[31]), 32'h5C);

        // MEM_LAT=3 read: mem_en cycle 1, capture end of cycle 4, ack cycle 5
        @(posedge clk);
        #1;
        b_creq  = 1'b1;
        b_caddr = 5'd5;
        @(negedge clk);
        chk("l3_c0_busy", 0, 32'(b_busy), 0);
        @(negedge clk);
        chk("l3_c1_en", 1, 32'({b_men, b_cgnt, b_maddr}), 32'({2'b11, 5'd5}));
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk("l3_wait", c, 32'({b_men, b_cack, b_cgnt, b_crd}),
                32'({3'b001, 8'h00}));
        end
        @(negedge clk);
        chk("l3_c5_ack", 5, 32'({b_cack, b_cgnt, b_crd}),
            32'({2'b11, 8'hD2}));
        @(posedge clk);
        #1 b_creq = 1'b0;
        @(negedge clk);
        chk("l3_c6_idle", 6, 32'({b_cack, b_busy, b_crd}),
            32'({2'b00, 8'hD2}));

        // reset in the middle of WAIT aborts the transaction
        @(posedge clk);
        #1;
        b_creq  = 1'b1;
        b_caddr = 5'd6;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        b_creq = 1'b0;
        #1;
        chk("abort_ctl", 0, 32'({b_cgnt, b_men, b_busy, b_cack}), 0);
        chk("abort_data", 0, 32'({b_crd, b_maddr}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (b_cack || b_cgnt || b_busy) seen = 1'b1;
        end
        chk("no_ack_after_rst", 0, 32'(seen), 0);

        @(posedge clk);
        #1;
        b_creq  = 1'b1;
        b_dreq  = 1'b1;
        b_caddr = 5'd6;
        b_daddr = 5'd5;
        @(negedge clk);
        @(negedge clk);
        chk("first_gnt", 0, 32'({b_cgnt, b_dgnt, b_men}), 32'b101);
        repeat (4) @(negedge clk);
        chk("first_ack", 0, 32'({b_cack, b_crd}), 32'({1'b1, 8'hE7}));
        @(posedge clk);
        #1;
        b_creq = 1'b0;
        b_dreq = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
